// File: rtl/proab_sched_pkg.sv
// Shared definitions for the softmax probability-stage sequencer.
package proab_sched_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned RD_LAT_DEF  = 1;
    localparam int unsigned DIV_LAT_DEF = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/proab_tag_pipe.sv
// Valid-bit shift register that tracks operands travelling through fixed-latency logic.
// o_vld is the bit leaving the pipe; o_pre is the bit that will leave on the next cycle.
module proab_tag_pipe #(
    parameter int unsigned DEPTH = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vld,
    output logic o_vld,
    output logic o_pre
);

    logic [DEPTH-1:0] r_sr;

    // Shift one stage per cycle; reset drops every tag still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[DEPTH-2:0], i_vld};
        end
    end

    assign o_vld = r_sr[DEPTH-1];
    assign o_pre = r_sr[DEPTH-2];

endmodule

// File: rtl/proab_sched.sv
// Softmax probability sequencer: streams exponent words through an external
// pipelined divider (data / sum) and writes the quotients, one per cycle.
// Optional argmax tracking of the written quotients: define PROAB_ARGMAX_EN.
module proab_sched
    import proab_sched_pkg::*;
#(
    parameter int unsigned DW      = FP_W,
    parameter int unsigned AW      = 10,
    parameter int unsigned RD_LAT  = RD_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] sum_in,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] wr_base,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] div_a,
    output logic [DW-1:0] div_b,
    input  logic [DW-1:0] div_res,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
`ifdef PROAB_ARGMAX_EN
    ,
    output logic [AW-1:0] max_idx,
    output logic [DW-1:0] max_val
`endif
);

    localparam int unsigned CW    = AW + 1;
    localparam int unsigned TAG_D = RD_LAT + DIV_LAT;

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_accept;
    logic          r_busy;
    logic          r_done;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_div_b;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_issue_cnt;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] w_wr_cnt_nxt;
    logic          w_wr_en;
    logic          w_tag_pre;

    // Latency tracker: a tag enters with each read and exits with its quotient.
    proab_tag_pipe #(
        .DEPTH (TAG_D)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (r_rd_en),
        .o_vld (w_wr_en),
        .o_pre (w_tag_pre)
    );

    assign w_wr_cnt_nxt = r_wr_cnt + CW'(w_wr_en);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; FIN is timed to coincide with the final write so done follows it.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (len != '0) ? S_ISSUE : S_FIN;
                end
            end
            S_ISSUE: begin
                if (r_issue_cnt == r_len - CW'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_tag_pre && (w_wr_cnt_nxt == r_len - CW'(1))) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job registers, address counters and registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_div_b     <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_wr_cnt    <= '0;
        end else begin
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_FIN);
            r_rd_en <= (w_state_nxt == S_ISSUE);
            if (w_accept) begin
                r_len       <= len;
                r_div_b     <= sum_in;
                r_rd_addr   <= rd_base;
                r_wr_addr   <= wr_base;
                r_issue_cnt <= '0;
                r_wr_cnt    <= '0;
            end else begin
                if ((r_state == S_ISSUE) && (w_state_nxt == S_ISSUE)) begin
                    r_rd_addr   <= r_rd_addr + AW'(1);
                    r_issue_cnt <= r_issue_cnt + CW'(1);
                end
                if (w_wr_en) begin
                    r_wr_addr <= r_wr_addr + AW'(1);
                    r_wr_cnt  <= w_wr_cnt_nxt;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign div_a   = rd_data;
    assign div_b   = r_div_b;
    assign wr_en   = w_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = div_res;

`ifdef PROAB_ARGMAX_EN
    logic [AW-1:0] r_max_idx;
    logic [DW-1:0] r_max_val;

    // Running argmax over written quotients; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max_idx <= '0;
            r_max_val <= '0;
        end else if (w_accept) begin
            r_max_idx <= '0;
            r_max_val <= '0;
        end else if (w_wr_en && (div_res > r_max_val)) begin
            r_max_idx <= r_wr_cnt[AW-1:0];
            r_max_val <= div_res;
        end
    end

    assign max_idx = r_max_idx;
    assign max_val = r_max_val;
`endif

endmodule
